// File: rtl/cosmem_arbiter_if.sv
// Signal bundle between the COSMAC bus side, the host loader port, the
// arbiter and the registered-output cosmem BRAM.
interface cosmem_arbiter_if #(
   parameter int ADDR_W = 13
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;
   logic              cpu_stall;
   logic              cpu_overrun;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [7:0]        host_wdata;
   logic [7:0]        host_rdata;
   logic              host_ack;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_stall, cpu_overrun,
      input  host_req, host_we, host_addr, host_wdata,
      output host_rdata, host_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_stall, cpu_overrun,
      output host_req, host_we, host_addr, host_wdata,
      input  host_rdata, host_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/cosmem_arbiter.sv
// Single-port arbiter sharing the cosmem BRAM between the COSMAC bus (fixed
// priority, pulse requests) and a level-handshake host port with starvation guard.
module cosmem_arbiter #(
   parameter int ADDR_W        = 13,
   parameter int HOST_MAX_WAIT = 8,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             reset,
   cosmem_arbiter_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_CAPT  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   logic [1:0]        r_state;
   logic              r_win_host;
   logic              r_acc_we;
   logic              r_cpu_pend;
   logic              r_cpu_we;
   logic [ADDR_W-1:0] r_cpu_addr;
   logic [7:0]        r_cpu_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cpu_ack;
   logic              r_host_ack;
   logic              r_cpu_stall;
   logic              r_overrun;
   logic [7:0]        r_cpu_rdata;
   logic [7:0]        r_host_rdata;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;

   logic w_idle;
   logic w_starved;
   logic w_cpu_want;
   logic w_host_win;
   logic w_cpu_win;
   logic w_cpu_direct;
   logic w_host_waiting;
   logic w_cpu_busy_nxt;
   logic w_pend_nxt;
   logic w_latch;
   logic w_drop;

   generate
      if (HOST_MAX_WAIT == 0) begin : g_host_always
         assign w_starved = 1'b1;
      end else begin : g_host_counted
         assign w_starved = (r_cnt >= CNT_W'(HOST_MAX_WAIT));
      end
   endgenerate

   // A fresh cpu_req in IDLE competes exactly like a pended one.
   assign w_idle         = (r_state == ST_IDLE);
   assign w_cpu_want     = r_cpu_pend | bus.cpu_req;
   assign w_host_win     = w_idle & bus.host_req & (~w_cpu_want | w_starved);
   assign w_cpu_win      = w_idle & ~w_host_win & w_cpu_want;
   assign w_cpu_direct   = w_cpu_win & ~r_cpu_pend;
   assign w_host_waiting = bus.host_req & ~((r_state != ST_IDLE) & r_win_host);
   assign w_cpu_busy_nxt = w_cpu_win | ((r_state == ST_ISSUE) & ~r_win_host);

   always_comb begin
      w_pend_nxt = r_cpu_pend;
      w_latch    = 1'b0;
      w_drop     = 1'b0;
      if (bus.cpu_req && !w_cpu_direct) begin
         if (!r_cpu_pend || w_cpu_win) begin
            w_pend_nxt = 1'b1;
            w_latch    = 1'b1;
         end else begin
            w_drop = 1'b1;
         end
      end else if (w_cpu_win) begin
         w_pend_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpu_pend  <= 1'b0;
         r_cpu_we    <= 1'b0;
         r_cpu_addr  <= '0;
         r_cpu_wdata <= '0;
         r_overrun   <= 1'b0;
         r_cpu_stall <= 1'b0;
      end else begin
         r_cpu_pend  <= w_pend_nxt;
         r_cpu_stall <= w_pend_nxt & ~w_cpu_busy_nxt;
         if (w_drop) r_overrun <= 1'b1;
         if (w_latch) begin
            r_cpu_we    <= bus.cpu_we;
            r_cpu_addr  <= bus.cpu_addr;
            r_cpu_wdata <= bus.cpu_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_host_win) begin
         r_cnt <= '0;
      end else if (w_host_waiting && r_cnt != CNT_SAT) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_win_host   <= 1'b0;
         r_acc_we     <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_host_ack   <= 1'b0;
         r_cpu_rdata  <= '0;
         r_host_rdata <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_cpu_ack  <= 1'b0;
         r_host_ack <= 1'b0;
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_host_win) begin
                  r_state     <= ST_ISSUE;
                  r_win_host  <= 1'b1;
                  r_acc_we    <= bus.host_we;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= bus.host_we;
                  r_mem_addr  <= bus.host_addr;
                  r_mem_wdata <= bus.host_wdata;
               end else if (w_cpu_win) begin
                  r_state    <= ST_ISSUE;
                  r_win_host <= 1'b0;
                  r_mem_en   <= 1'b1;
                  if (r_cpu_pend) begin
                     r_acc_we    <= r_cpu_we;
                     r_mem_we    <= r_cpu_we;
                     r_mem_addr  <= r_cpu_addr;
                     r_mem_wdata <= r_cpu_wdata;
                  end else begin
                     r_acc_we    <= bus.cpu_we;
                     r_mem_we    <= bus.cpu_we;
                     r_mem_addr  <= bus.cpu_addr;
                     r_mem_wdata <= bus.cpu_wdata;
                  end
               end
            end
            ST_ISSUE: r_state <= ST_CAPT;
            ST_CAPT: begin
               // BRAM output is valid here; latch it only for reads.
               r_state <= ST_IDLE;
               if (r_win_host) begin
                  r_host_ack <= 1'b1;
                  if (!r_acc_we) r_host_rdata <= bus.mem_rdata;
               end else begin
                  r_cpu_ack <= 1'b1;
                  if (!r_acc_we) r_cpu_rdata <= bus.mem_rdata;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cpu_rdata   = r_cpu_rdata;
   assign bus.cpu_ack     = r_cpu_ack;
   assign bus.cpu_stall   = r_cpu_stall;
   assign bus.cpu_overrun = r_overrun;
   assign bus.host_rdata  = r_host_rdata;
   assign bus.host_ack    = r_host_ack;
   assign bus.mem_en      = r_mem_en;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
endmodule
